cva6_uart_tx_periph: RTL

//   Memory-mapped UART transmitter. Sits on the core data bus next to the data RAM and LED register.

---
 rtl/cva6_uart_tx_periph.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/cva6_uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a programmable bit period.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame (8E1).
module cva6_uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned CLK_FREQ_HZ = 125000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_DIV_RST = 16'(CLK_FREQ_HZ / BAUD);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  localparam logic PARITY_FLAG = 1'b0;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Bus handshake: there is no ready. A cycle with req=1 is an access that completes in
  // that same cycle; writes commit on the closing clk edge, reads return combinationally.
  logic [31:0] offset;
  logic        wr;
  logic        push_req;
  logic        stat_wr;
  logic        baud_wr;

  assign offset   = addr - BASE_ADDR;
  assign sel      = (offset < 32'd12) && (addr[1:0] == 2'b00);
  assign wr       = req & we & sel;
  assign push_req = wr & be[0] & (offset[3:2] == 2'd0);
  assign stat_wr  = wr & (offset[3:2] == 2'd1);
  assign baud_wr  = wr & (offset[3:2] == 2'd2);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          overflow;
  logic [15:0]   baud_div;
  logic [15:0]   reload;

  state_t      state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
`ifdef UART_TX_PARITY_EN
  logic        par_bit;
`endif

  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  // Full is judged on the registered count, so a pop in the same cycle cannot make room.
  assign push   = push_req & ~full;
  assign pop    = ~empty & ((state == S_IDLE) | ((state == S_STOP) & (bit_cnt == 16'd0)));
  assign reload = ((baud_div < 16'd2) ? 16'd2 : baud_div) - 16'd1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud_div <= BAUD_DIV_RST;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push_req & full)
        overflow <= 1'b1;
      else if (stat_wr & be[0] & wdata[3])
        overflow <= 1'b0;
      if (baud_wr & be[0]) baud_div[7:0]  <= wdata[7:0];
      if (baud_wr & be[1]) baud_div[15:8] <= wdata[15:8];
    end
  end

  // Each bit holds for reload+1 clocks; bit_cnt is reloaded on every bit entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      uart_tx <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shreg   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par_bit <= ^mem[rd_ptr];
`endif
            bit_cnt <= reload;
            state   <= S_START;
            uart_tx <= 1'b0;
          end
        end
        S_START: begin
          if (bit_cnt == 16'd0) begin
            state   <= S_DATA;
            uart_tx <= shreg[0];
            bit_idx <= '0;
            bit_cnt <= reload;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_cnt == 16'd0) begin
            bit_cnt <= reload;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
              uart_tx <= par_bit;
`else
              state   <= S_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              uart_tx <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_cnt == 16'd0) begin
            state   <= S_STOP;
            uart_tx <= 1'b1;
            bit_cnt <= reload;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_cnt == 16'd0) begin
            if (pop) begin
              shreg   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
              par_bit <= ^mem[rd_ptr];
`endif
              bit_cnt <= reload;
              state   <= S_START;
              uart_tx <= 1'b0;
            end else begin
              state   <= S_IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

  logic        fsm_busy;
  logic [3:0]  count4;
  logic [31:0] status;
  logic        unused_bits;

  assign fsm_busy    = (state != S_IDLE);
  assign tx_busy     = fsm_busy | ~empty;
  assign count4      = 4'(count);
  assign status      = {23'd0, PARITY_FLAG, count4, overflow, fsm_busy, empty, full};
  assign unused_bits = ^{wdata[31:16], be[3:2]};

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (offset[3:2])
        2'd1:    rdata = status;
        2'd2:    rdata = {16'd0, baud_div};
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule
